antirrebote_gray: RTL and testbench
===================================

ANTIRREBOTE_GRAY -- requirements
Module: antirrebote_gray

Interface
REQ-001 SHALL provide parameter MUESTRAS, default 100, number of consecutive equal samples needed to accept a new input value (10 ms at 10 kHz).
REQ-002 SHALL provide parameter ANCHO, default 4, width of the Gray-code switch vector.
REQ-003 SHALL provide port clk, input, 1 bit, 100 MHz system clock; all flops on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL provide port clk_dividido, input, 1 bit, 10 kHz square wave from the clock divider, generated in the clk domain.
REQ-006 SHALL provide port sw, input, ANCHO bits, raw asynchronous board switches carrying a Gray code.
REQ-007 SHALL provide port gray_estable, output, ANCHO bits, debounced Gray code for the Gray decoder.
REQ-008 SHALL provide port cambio, output, 1 bit, one-clk pulse when gray_estable takes a new value.

Function
REQ-009 SHALL pass sw through a two-flop synchronizer in clk; the second-stage value is sw_sinc.
REQ-010 SHALL register clk_dividido once (clk_div_prev) and form muestra = clk_dividido AND NOT clk_div_prev, one clk cycle per divided period; clk_dividido SHALL never be used as a clock.
REQ-011 SHALL hold a candidate register (ANCHO bits) and a sample counter of width ceil(log2(MUESTRAS))+1.
REQ-012 On muestra with sw_sinc != candidato: candidato <= sw_sinc, contador <= 1.
REQ-013 On muestra with sw_sinc == candidato and contador < MUESTRAS: contador <= contador + 1.
REQ-014 Counter SHALL saturate at MUESTRAS; no wrap-around.
REQ-015 On the clk edge where contador reaches MUESTRAS and candidato != gray_estable: gray_estable <= candidato and cambio <= 1.
REQ-016 Without muestra, candidato, contador and gray_estable SHALL hold.
REQ-017 cambio SHALL be 1 for exactly one clk cycle per accepted change and 0 otherwise, including when the settled candidate equals gray_estable.
REQ-018 Any sample differing from candidato before saturation SHALL restart the count; a bounce pattern never yields MUESTRAS equal samples and never updates gray_estable.
REQ-019 Latency: gray_estable SHALL update one clk after the MUESTRAS-th consecutive muestra that sees the new value (sw_sinc lags sw by 2 clk).
REQ-020 If clk_dividido stops toggling, gray_estable SHALL hold indefinitely.

Reset
REQ-021 While reset is 0: synchronizer flops, clk_div_prev, candidato, contador, gray_estable and cambio SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, counting restarts from candidato = 0.
REQ-023 Deassertion SHALL be sampled by clk; the first muestra is the first rising clk_dividido seen after release.

Structure
REQ-024 Shared package/include gray_pkg SHALL hold ANCHO_GRAY = 4 and MUESTRAS_ANTIRREBOTE = 100, also used by the Gray decoder.
REQ-025 The two-flop synchronizer SHALL be a sub-module named sincronizador, parameterized by width, instantiated once.
REQ-026 Edge detect, counter and stable register SHALL reside in antirrebote_gray; no latches, no derived clocks.

Verification
REQ-027 Reset: reset=0 with sw=4'b1010 -> gray_estable=0, cambio=0; release, hold 1010 for 100 muestras -> gray_estable=1010, single cambio pulse.
REQ-028 Clean change (bench MUESTRAS=4): sw 0000->0001, held -> gray_estable=0001 one clk after the 4th muestra; cambio high exactly one cycle.
REQ-029 Bounce (MUESTRAS=4): sw toggles 0001/0011 every muestra for 20 muestras, then holds 0011 -> gray_estable stays 0001 during bounce, becomes 0011 after 4 stable muestras.
REQ-030 Glitch back (MUESTRAS=4): from stable 0011, sw=0010 for 2 muestras then back to 0011 -> no update, no cambio.
REQ-031 Reset mid-count (MUESTRAS=4): sw=0110 for 3 muestras, pulse reset -> outputs 0; after release, 4 muestras -> gray_estable=0110.
REQ-032 Stopped divider: clk_dividido held 1 for 10000 clk while sw changes -> gray_estable and cambio unchanged.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code switch path: debouncer and Gray decoder.
package gray_pkg;
  localparam int ANCHO_GRAY           = 4;
  localparam int MUESTRAS_ANTIRREBOTE = 100;
endpackage : gray_pkg

// File: rtl/sincronizador.sv
// Two-flop synchronizer bringing the asynchronous switch vector into the clk domain.
module sincronizador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] d,
  output logic [ANCHO-1:0] q
);

  logic [ANCHO-1:0] etapa1_r;
  logic [ANCHO-1:0] etapa2_r;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      etapa1_r <= {ANCHO{1'b0}};
      etapa2_r <= {ANCHO{1'b0}};
    end else begin
      etapa1_r <= d;
      etapa2_r <= etapa1_r;
    end
  end

  assign q = etapa2_r;

endmodule : sincronizador

// File: rtl/antirrebote_gray.sv
// Debouncer for a Gray-coded switch bank: a new value is accepted only after
// MUESTRAS consecutive equal samples taken on rising edges of clk_dividido.
module antirrebote_gray
  import gray_pkg::*;
#(
  parameter int MUESTRAS = MUESTRAS_ANTIRREBOTE,
  parameter int ANCHO    = ANCHO_GRAY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_dividido,
  input  logic [ANCHO-1:0] sw,
  output logic [ANCHO-1:0] gray_estable,
  output logic             cambio
);

  localparam int               CW         = $clog2(MUESTRAS) + 1;
  localparam logic [CW-1:0]    MUESTRAS_C = CW'(MUESTRAS);
  localparam logic [CW-1:0]    UNO_C      = CW'(1);

  logic [ANCHO-1:0] sw_sinc_s;
  logic             clk_div_prev_r;
  logic [ANCHO-1:0] candidato_r;
  logic [CW-1:0]    contador_r;
  logic [ANCHO-1:0] gray_estable_r;
  logic             cambio_r;
  logic             muestra_s;
  logic             aceptar_s;

  sincronizador #(
    .ANCHO (ANCHO)
  ) u_sincronizador (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_sinc_s)
  );

  // Sample strobe and acceptance condition; the divider is only ever treated as data.
  always_comb begin
    muestra_s = 1'b0;
    aceptar_s = 1'b0;
    if (clk_dividido && !clk_div_prev_r) begin
      muestra_s = 1'b1;
    end else begin
      muestra_s = 1'b0;
    end
    if ((contador_r == MUESTRAS_C) && (candidato_r != gray_estable_r)) begin
      aceptar_s = 1'b1;
    end else begin
      aceptar_s = 1'b0;
    end
  end

  // Candidate tracking, saturating run counter and the accepted stable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_div_prev_r <= 1'b0;
      candidato_r    <= {ANCHO{1'b0}};
      contador_r     <= {CW{1'b0}};
      gray_estable_r <= {ANCHO{1'b0}};
      cambio_r       <= 1'b0;
    end else begin
      clk_div_prev_r <= clk_dividido;
      if (muestra_s) begin
        if (sw_sinc_s != candidato_r) begin
          candidato_r <= sw_sinc_s;
          contador_r  <= UNO_C;
        end else if (contador_r < MUESTRAS_C) begin
          contador_r <= contador_r + UNO_C;
        end
      end
      // Acceptance looks at the registered count, so it lands one clk after the last sample.
      if (aceptar_s) begin
        gray_estable_r <= candidato_r;
        cambio_r       <= 1'b1;
      end else begin
        cambio_r <= 1'b0;
      end
    end
  end

  assign gray_estable = gray_estable_r;
  assign cambio       = cambio_r;

endmodule : antirrebote_gray

// File: tb/tb_antirrebote_gray.sv
// Directed bench for antirrebote_gray with a short sample run (MUESTRAS = 4).
module tb_antirrebote_gray;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_dividido = 1'b0;
  logic [3:0] sw = 4'b1010;
  logic [3:0] gray_estable;
  logic       cambio;

  int checks = 0;
  int errors = 0;
  int n_cambio = 0;

  antirrebote_gray #(
    .MUESTRAS (4),
    .ANCHO    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_dividido (clk_dividido),
    .sw           (sw),
    .gray_estable (gray_estable),
    .cambio       (cambio)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with cambio high.
  always @(negedge clk) begin
    if (cambio === 1'b1) n_cambio <= n_cambio + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One divided period: the first rising edge inside is the sample edge.
  task automatic tick(input int n);
    repeat (n) begin
      clk_dividido = 1'b1;
      step(4);
      clk_dividido = 1'b0;
      step(4);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw = v;
    step(3);
  endtask

  task automatic test_reset;
    int base;
    step(3);
    checks++;
    if (gray_estable !== 4'b0000) begin
      errors++;
      $display("FAIL reset_estable: got %b expected 0000", gray_estable);
    end
    checks++;
    if (cambio !== 1'b0) begin
      errors++;
      $display("FAIL reset_cambio: got %b expected 0", cambio);
    end
    reset = 1'b1;
    set_sw(4'b1010);
    base = n_cambio;
    tick(100);
    checks++;
    if (gray_estable !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release_estable: got %b expected 1010", gray_estable);
    end
    checks++;
    if (n_cambio - base !== 1) begin
      errors++;
      $display("FAIL reset_release_pulses: got %0d expected 1", n_cambio - base);
    end
  endtask

  task automatic test_clean_change;
    int base;
    set_sw(4'b0000);
    tick(4);
    checks++;
    if (gray_estable !== 4'b0000) begin
      errors++;
      $display("FAIL clean_to_zero: got %b expected 0000", gray_estable);
    end
    set_sw(4'b0001);
    base = n_cambio;
    tick(3);
    checks++;
    if (gray_estable !== 4'b0000) begin
      errors++;
      $display("FAIL clean_after3: got %b expected 0000", gray_estable);
    end
    clk_dividido = 1'b1;
    step(1);
    checks++;
    if (gray_estable !== 4'b0000 || cambio !== 1'b0) begin
      errors++;
      $display("FAIL clean_4th_edge: got %b/%b expected 0000/0", gray_estable, cambio);
    end
    step(1);
    checks++;
    if (gray_estable !== 4'b0001 || cambio !== 1'b1) begin
      errors++;
      $display("FAIL clean_update: got %b/%b expected 0001/1", gray_estable, cambio);
    end
    step(1);
    checks++;
    if (cambio !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulse_end: got %b expected 0", cambio);
    end
    step(1);
    clk_dividido = 1'b0;
    step(4);
    checks++;
    if (n_cambio - base !== 1) begin
      errors++;
      $display("FAIL clean_pulses: got %0d expected 1", n_cambio - base);
    end
  endtask

  task automatic test_bounce;
    int base;
    base = n_cambio;
    for (int i = 0; i < 20; i++) begin
      set_sw((i % 2 == 0) ? 4'b0011 : 4'b0001);
      tick(1);
      checks++;
      if (gray_estable !== 4'b0001) begin
        errors++;
        $display("FAIL bounce_hold_%0d: got %b expected 0001", i, gray_estable);
      end
    end
    set_sw(4'b0011);
    tick(3);
    checks++;
    if (gray_estable !== 4'b0001 || n_cambio != base) begin
      errors++;
      $display("FAIL bounce_settle3: got %b/%0d expected 0001/0", gray_estable, n_cambio - base);
    end
    tick(1);
    checks++;
    if (gray_estable !== 4'b0011 || n_cambio - base !== 1) begin
      errors++;
      $display("FAIL bounce_settle4: got %b/%0d expected 0011/1", gray_estable, n_cambio - base);
    end
  endtask

  task automatic test_glitch_back;
    int base;
    base = n_cambio;
    set_sw(4'b0010);
    tick(2);
    set_sw(4'b0011);
    tick(6);
    checks++;
    if (gray_estable !== 4'b0011 || n_cambio != base) begin
      errors++;
      $display("FAIL glitch_back: got %b/%0d expected 0011/0", gray_estable, n_cambio - base);
    end
  endtask

  task automatic test_reset_mid_count;
    int base;
    set_sw(4'b0110);
    tick(3);
    reset = 1'b0;
    #1;
    checks++;
    if (gray_estable !== 4'b0000 || cambio !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got %b/%b expected 0000/0", gray_estable, cambio);
    end
    step(2);
    reset = 1'b1;
    base = n_cambio;
    step(3);
    tick(3);
    checks++;
    if (gray_estable !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_after3: got %b expected 0000", gray_estable);
    end
    tick(1);
    checks++;
    if (gray_estable !== 4'b0110 || n_cambio - base !== 1) begin
      errors++;
      $display("FAIL midreset_after4: got %b/%0d expected 0110/1", gray_estable, n_cambio - base);
    end
  endtask

  task automatic test_stopped_divider;
    int base;
    base = n_cambio;
    clk_dividido = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      step(1000);
    end
    checks++;
    if (gray_estable !== 4'b0110 || n_cambio != base) begin
      errors++;
      $display("FAIL stopped_divider: got %b/%0d expected 0110/0", gray_estable, n_cambio - base);
    end
    clk_dividido = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_clean_change();
    test_bounce();
    test_glitch_back();
    test_reset_mid_count();
    test_stopped_divider();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_antirrebote_gray
